// File: rtl/crop_window_if.sv
// Pixel stream bundle for crop_window: input stream, cropped output stream, frame pulse.
// Optional out_last exists only when CROP_LAST_EN is defined.
interface crop_window_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_done;
`ifdef CROP_LAST_EN
    logic                  out_last;
`endif

    // master: pixel source / downstream sink side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, frame_done
`ifdef CROP_LAST_EN
        , input out_last
`endif
    );

    // slave: the crop block itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, frame_done
`ifdef CROP_LAST_EN
        , output out_last
`endif
    );
endinterface

// File: rtl/crop_window.sv
// Raster crop: keeps the CROP_W x CROP_H window at (CROP_X,CROP_Y), 1-cycle latency,
// single output register; in_ready = !out_valid || out_ready. Define CROP_LAST_EN for out_last.
module crop_window #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int CROP_X     = 0,
    parameter int CROP_Y     = 0,
    parameter int CROP_W     = 20,
    parameter int CROP_H     = 20
) (
    input  logic         clk,
    input  logic         reset,
    crop_window_if.slave bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic                  done_q, done_d;

    logic in_xfer, out_xfer, keep, col_end, row_end;
    int   col_i, row_i;

    assign col_i    = int'(col_q);
    assign row_i    = int'(row_q);
    assign col_end  = (col_i == IMG_WIDTH - 1);
    assign row_end  = (row_i == IMG_HEIGHT - 1);
    assign keep     = (col_i >= CROP_X) && (col_i < CROP_X + CROP_W) &&
                      (row_i >= CROP_Y) && (row_i < CROP_Y + CROP_H);

    assign bus.in_ready   = !vld_q || bus.out_ready;
    assign in_xfer        = bus.in_valid && bus.in_ready;
    assign out_xfer       = vld_q && bus.out_ready;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = vld_q;
    assign bus.frame_done = done_q;

`ifdef CROP_LAST_EN
    logic last_q, last_d;
    assign bus.out_last = last_q;
`endif

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        data_d = data_q;
        vld_d  = vld_q;
        done_d = 1'b0;
`ifdef CROP_LAST_EN
        last_d = last_q;
`endif
        if (out_xfer) begin
            vld_d = 1'b0;
        end
        if (in_xfer) begin
            // counters wrap explicitly so non-power-of-two sizes never overrun
            col_d  = col_end ? '0 : col_q + CW'(1);
            if (col_end) begin
                row_d = row_end ? '0 : row_q + RW'(1);
            end
            done_d = col_end && row_end;
            if (keep) begin
                data_d = bus.in_data;
                vld_d  = 1'b1;
`ifdef CROP_LAST_EN
                last_d = (col_i == CROP_X + CROP_W - 1) && (row_i == CROP_Y + CROP_H - 1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef CROP_LAST_EN
            last_q <= 1'b0;
`endif
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            done_q <= done_d;
`ifdef CROP_LAST_EN
            last_q <= last_d;
`endif
        end
    end
endmodule

// File: doc/crop_window.md
CROP_WINDOW -- requirements
Module: crop_window

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 12, meaning pixel width in bits.
REQ-002 The block SHALL expose parameter IMG_WIDTH, default 64, meaning input frame columns.
REQ-003 The block SHALL expose parameter IMG_HEIGHT, default 64, meaning input frame rows.
REQ-004 The block SHALL expose parameter CROP_X, default 0, meaning first kept column.
REQ-005 The block SHALL expose parameter CROP_Y, default 0, meaning first kept row.
REQ-006 The block SHALL expose parameter CROP_W, default 20, meaning kept columns.
REQ-007 The block SHALL expose parameter CROP_H, default 20, meaning kept rows; CROP_X+CROP_W<=IMG_WIDTH and CROP_Y+CROP_H<=IMG_HEIGHT.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 in_data  input  DATA_WIDTH  raster-order input pixel.
REQ-011 in_valid  input  1  in_data valid.
REQ-012 in_ready  output  1  block accepts in_data this cycle.
REQ-013 out_data  output  DATA_WIDTH  cropped pixel (feeds downstream FIFO).
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 frame_done  output  1  one-cycle pulse after last input pixel of a frame is accepted.
REQ-017 out_last  output  1  present only with CROP_LAST_EN; marks final cropped pixel of frame.

Function
REQ-018 Input transfer SHALL occur iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational), independent of whether the pixel is kept.
REQ-020 Column counter col SHALL increment per input transfer, wrapping IMG_WIDTH-1 -> 0; row counter SHALL increment on col wrap, wrapping IMG_HEIGHT-1 -> 0.
REQ-021 A pixel SHALL be kept iff CROP_X<=col<CROP_X+CROP_W and CROP_Y<=row<CROP_Y+CROP_H, evaluated on the counters before increment.
REQ-022 A kept pixel SHALL be registered into out_data with out_valid=1 on the clock edge of its input transfer (latency 1 cycle).
REQ-023 A discarded pixel SHALL be consumed with no change to out_data/out_valid except clearing out_valid if an output transfer occurs the same cycle.
REQ-024 Simultaneous output transfer and kept input transfer SHALL replace out_data with no bubble; output transfer alone SHALL clear out_valid.
REQ-025 out_data SHALL hold stable while out_valid && !out_ready.
REQ-026 frame_done SHALL pulse for exactly one cycle the edge after accepting the pixel at col=IMG_WIDTH-1, row=IMG_HEIGHT-1; next frame starts at col=0,row=0 with no gap.
REQ-027 Counters SHALL be sized $clog2 of their range (minimum 1 bit) and never exceed IMG_WIDTH-1 / IMG_HEIGHT-1.

Reset
REQ-028 On reset: col=0, row=0, out_data=0, out_valid=0, frame_done=0, out_last=0.
REQ-029 Reset mid-frame SHALL discard the held pixel and partial frame; the first transfer after reset SHALL be treated as col=0,row=0.

Configuration
REQ-030 With macro CROP_LAST_EN defined, out_last SHALL be registered with out_data, 1 on the pixel at col=CROP_X+CROP_W-1,row=CROP_Y+CROP_H-1, else 0, held while stalled.
REQ-031 Without CROP_LAST_EN, port out_last and its logic SHALL not exist; all other behaviour identical.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, CROP_X=2, CROP_Y=1, CROP_W=3, CROP_H=2, DATA_WIDTH=12, pixel value=row*8+col)
REQ-032 Full frame, in_valid=1, out_ready=1 -> outputs exactly 10,11,12,18,19,20 in order; frame_done one pulse after pixel 47.
REQ-033 Same frame, out_ready toggling 1/0 each cycle -> same 6 values, none lost/duplicated, out_data stable while stalled, in_ready low only while stalled with data held.
REQ-034 Two back-to-back frames -> 12 outputs (10..20 set twice), two frame_done pulses 48 transfers apart.
REQ-035 Reset asserted after pixel 11 accepted, then new full frame -> out_valid=0 after reset, then exactly 10,11,12,18,19,20.
REQ-036 CROP_LAST_EN defined -> out_last=1 only with out_data=20; undefined -> port absent, outputs as REQ-032.
